// File: rtl/fp_sqrt_pkg.sv
// Shared types and IEEE-754 special-case classification for the sqrt issue controller.
package fp_sqrt_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_e;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;
  localparam logic [31:0] PINF = 32'h7F80_0000;

  typedef struct packed {
    logic        is_special;
    logic [31:0] result;
  } class_t;

  // First matching rule wins; denormals are flushed to signed zero.
  function automatic class_t classify(input logic [31:0] d);
    class_t c;
    c.is_special = 1'b1;
    c.result     = '0;
    if (d[30:23] == 8'hFF && d[22:0] != '0) begin
      c.result = d | 32'h0040_0000;
    end else if (d[30:23] == 8'h00) begin
      c.result = {d[31], 31'b0};
    end else if (d[31]) begin
      c.result = QNAN;
    end else if (d[30:23] == 8'hFF) begin
      c.result = PINF;
    end else begin
      c.is_special = 1'b0;
    end
    return c;
  endfunction

endpackage

// File: rtl/fp_req_fifo.sv
// Small synchronous request FIFO with wrap-around pointers and an occupancy count.
module fp_req_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 36
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign head    = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clock) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      count_q <= count_q + 1'b1;
      else if (do_pop && !do_push) count_q <= count_q - 1'b1;
    end
  end

endmodule

// File: rtl/fp_sqrt_issue_ctrl.sv
// Front-end for the iterative sqrt unit: buffers tagged operands, resolves IEEE
// special cases locally, sequences the root unit and guards it with a watchdog.
module fp_sqrt_issue_ctrl
  import fp_sqrt_pkg::*;
#(
  parameter int DEPTH   = 2,
  parameter int TAG_W   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_d,
  input  logic [TAG_W-1:0] in_tag,
  output logic             root_start,
  output logic [31:0]      root_d,
  input  logic [31:0]      root_q,
  input  logic             root_busy,
  input  logic             root_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_q,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err
);

  localparam int W  = 32 + TAG_W;
  localparam int CW = $clog2(TIMEOUT + 1);

  state_e           state_q, state_d;
  logic [31:0]      op_q, op_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [31:0]      res_q, res_d;
  logic             err_q, err_d;
  logic [CW-1:0]    wd_q, wd_d;

  logic             fifo_full, fifo_empty, fifo_pop;
  logic [W-1:0]     fifo_head;
  class_t           head_cls;
  logic             unused_root_busy;

  fp_req_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (W)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (in_valid),
    .pop   (fifo_pop),
    .wdata ({in_tag, in_d}),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (fifo_head)
  );

  assign head_cls         = classify(fifo_head[31:0]);
  assign in_ready         = !fifo_full;
  assign root_d           = op_q;
  assign out_valid        = (state_q == HOLD);
  assign out_q            = res_q;
  assign out_tag          = tag_q;
  assign out_err          = err_q;
  assign unused_root_busy = root_busy;

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    tag_d      = tag_q;
    res_d      = res_q;
    err_d      = err_q;
    wd_d       = wd_q;
    fifo_pop   = 1'b0;
    root_start = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          op_d     = fifo_head[31:0];
          tag_d    = fifo_head[W-1:32];
          if (head_cls.is_special) begin
            res_d   = head_cls.result;
            err_d   = 1'b0;
            state_d = HOLD;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        root_start = 1'b1;
        wd_d       = '0;
        state_d    = WAIT;
      end
      WAIT: begin
        // root_ready wins over the watchdog on the final WAIT cycle
        if (root_ready) begin
          res_d   = root_q;
          err_d   = 1'b0;
          state_d = HOLD;
        end else if (wd_q == CW'(TIMEOUT - 1)) begin
          res_d   = QNAN;
          err_d   = 1'b1;
          state_d = HOLD;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      HOLD: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= '0;
      tag_q   <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      tag_q   <= tag_d;
      res_q   <= res_d;
      err_q   <= err_d;
      wd_q    <= wd_d;
    end
  end

endmodule

// File: tb/tb_fp_sqrt_issue_ctrl.sv
// Bench for fp_sqrt_issue_ctrl: directed latency/corner cases plus randomized
// traffic against a transaction-level result model and a behavioural root unit.
module tb_fp_sqrt_issue_ctrl;

  localparam int DEPTH = 2;
  localparam int TAG_W = 4;
  localparam int TMO   = 16;

  logic             clock = 1'b0;
  logic             reset;
  logic             in_valid, in_ready;
  logic [31:0]      in_d;
  logic [TAG_W-1:0] in_tag;
  logic             root_start;
  logic [31:0]      root_d, root_q;
  logic             root_busy, root_ready;
  logic             out_valid, out_ready;
  logic [31:0]      out_q;
  logic [TAG_W-1:0] out_tag;
  logic             out_err;

  always #5 clock = ~clock;

  fp_sqrt_issue_ctrl #(.DEPTH(DEPTH), .TAG_W(TAG_W), .TIMEOUT(TMO)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_d(in_d), .in_tag(in_tag),
    .root_start(root_start), .root_d(root_d), .root_q(root_q),
    .root_busy(root_busy), .root_ready(root_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_q(out_q),
    .out_tag(out_tag), .out_err(out_err)
  );

  typedef struct {
    logic [31:0]      q;
    logic [TAG_W-1:0] tag;
    logic             err;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] issue_q[$];
  int n_tests = 0, n_fail = 0;
  int cyc = 0, push_cyc = 0, n_starts = 0;
  int rm_delay = 0, rm_cnt = 0;
  logic rm_inject = 1'b0;
  logic [31:0] rm_d = '0;
  logic prod_done = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Behavioural root unit: halves the unbiased exponent; hangs on a marker byte.
  function automatic logic hangs(input logic [31:0] d);
    return d[7:0] == 8'hA5;
  endfunction

  function automatic logic [31:0] root_fn(input logic [31:0] d);
    int e = int'(d[30:23]);
    logic [22:0] m = d[22:0] >> 1;
    logic [7:0] re = 8'((e + 127) / 2);
    return {1'b0, re, m};
  endfunction

  function automatic logic needs_root(input logic [31:0] d);
    int e = int'(d[30:23]);
    return (d[31] == 1'b0) && (e != 0) && (e != 255);
  endfunction

  function automatic exp_t ref_out(input logic [31:0] d, input logic [TAG_W-1:0] t);
    exp_t r;
    int e = int'(d[30:23]);
    int unsigned f = int'(d[22:0]);
    r.tag = t;
    r.err = 1'b0;
    if (e == 255 && f != 0)  r.q = d | 32'h0040_0000;
    else if (e == 0)         r.q = d[31] ? 32'h8000_0000 : 32'h0;
    else if (d[31])          r.q = 32'h7FC0_0000;
    else if (e == 255)       r.q = 32'h7F80_0000;
    else if (hangs(d)) begin r.q = 32'h7FC0_0000; r.err = 1'b1; end
    else                     r.q = root_fn(d);
    return r;
  endfunction

  function automatic logic [31:0] rand_operand();
    logic [31:0] d = $urandom;
    case ($urandom_range(0, 7))
      0: begin d[30:23] = 8'hFF; d[1] = 1'b1; end
      1: begin d[30:23] = 8'h00; if ($urandom_range(0, 1) == 1) d[22:0] = '0; end
      2: begin d[31] = 1'b1; d[30:23] = 8'($urandom_range(1, 254)); end
      3: d[30:0] = 31'h7F80_0000;
      4: begin d[31] = 1'b0; d[30:23] = 8'($urandom_range(1, 254)); d[7:0] = 8'hA5; end
      default: begin d[31] = 1'b0; d[30:23] = 8'($urandom_range(1, 254)); end
    endcase
    return d;
  endfunction

  // Root unit model; also checks every issued operand against the expected issue order.
  initial begin
    root_ready = 1'b0;
    root_q     = '0;
    root_busy  = 1'b0;
    forever begin
      @(negedge clock);
      root_ready = 1'b0;
      if (reset) begin
        rm_cnt = 0;
      end else if (rm_cnt > 0) begin
        rm_cnt--;
        if (rm_cnt == 0) begin
          root_ready = 1'b1;
          root_q     = root_fn(rm_d);
        end
      end
      if (rm_inject) begin
        root_ready = 1'b1;
        root_q     = 32'h1234_5678;
        rm_inject  = 1'b0;
      end
      if (root_start && !reset) begin
        n_starts++;
        if (issue_q.size() == 0) check("start_unexpected", 64'(root_start), 64'd0);
        else check("root_d", root_d, issue_q.pop_front());
        rm_d = root_d;
        if (!hangs(root_d)) rm_cnt = (rm_delay != 0) ? rm_delay : $urandom_range(1, TMO);
      end
      root_busy = (rm_cnt > 0);
    end
  end

  task automatic push_one(input logic [31:0] d, input logic [TAG_W-1:0] t, output logic acc);
    in_valid = 1'b1;
    in_d     = d;
    in_tag   = t;
    acc      = in_ready;
    @(posedge clock);
    if (acc) begin
      exp_q.push_back(ref_out(d, t));
      if (needs_root(d)) issue_q.push_back(d);
    end
    @(negedge clock);
    in_valid = 1'b0;
    push_cyc = cyc;
  endtask

  task automatic wait_valid(input int lat, input string nm);
    int w = 0;
    while (out_valid !== 1'b1 && w < 200) begin
      @(negedge clock);
      w++;
    end
    check({nm, "_valid"}, 64'(out_valid), 64'd1);
    if (lat >= 0) check({nm, "_latency"}, 64'(cyc - push_cyc), 64'(lat));
  endtask

  task automatic compare_pop(input string nm);
    exp_t e;
    if (exp_q.size() == 0) begin
      check({nm, "_unexpected_result"}, 64'(out_valid), 64'd0);
      return;
    end
    e = exp_q.pop_front();
    check({nm, "_q"}, out_q, e.q);
    check({nm, "_tag"}, 64'(out_tag), 64'(e.tag));
    check({nm, "_err"}, 64'(out_err), 64'(e.err));
  endtask

  task automatic consume(input string nm);
    compare_pop(nm);
    out_ready = 1'b1;
    @(negedge clock);
    out_ready = 1'b0;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic acc;
    int   s0;
    reset = 1'b1; in_valid = 1'b0; in_d = '0; in_tag = '0; out_ready = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;

    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_root_start", 64'(root_start), 64'd0);
    check("rst_root_d", root_d, 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_q", out_q, 64'd0);
    check("rst_out_tag", 64'(out_tag), 64'd0);
    check("rst_out_err", 64'(out_err), 64'd0);

    // 4.0 -> 2.0 with a 5-cycle root latency
    rm_delay = 5;
    push_one(32'h4080_0000, 4'd3, acc);
    check("t1_acc", 64'(acc), 64'd1);
    check("t1_start_c1", 64'(root_start), 64'd0);
    @(negedge clock);
    check("t1_start_c2", 64'(root_start), 64'd1);
    check("t1_root_d", root_d, 64'h4080_0000);
    @(negedge clock);
    check("t1_start_c3", 64'(root_start), 64'd0);
    wait_valid(7, "t1");
    check("t1_q_const", out_q, 64'h4000_0000);
    consume("t1");

    // Specials never reach the root unit
    s0 = n_starts;
    push_one(32'hC000_0000, 4'd1, acc);
    check("t2_valid_c1", 64'(out_valid), 64'd0);
    push_one(32'h8000_0000, 4'd2, acc);
    check("t2_valid_c2", 64'(out_valid), 64'd1);
    push_one(32'h7F80_0001, 4'd3, acc);
    check("t2_acc3", 64'(acc), 64'd1);
    wait_valid(-1, "t2a"); check("t2a_const", out_q, 64'h7FC0_0000); consume("t2a");
    wait_valid(-1, "t2b"); check("t2b_const", out_q, 64'h8000_0000); consume("t2b");
    wait_valid(-1, "t2c"); check("t2c_const", out_q, 64'h7FC0_0001); consume("t2c");
    check("t2_no_start", 64'(n_starts), 64'(s0));

    // Fill: one op in flight plus two buffered; a fourth push is rejected
    rm_delay = 2;
    push_one(32'h4110_0000, 4'd4, acc); check("t3_acc_a", 64'(acc), 64'd1);
    push_one(32'h4180_0000, 4'd5, acc); check("t3_acc_b", 64'(acc), 64'd1);
    push_one(32'h42C8_0000, 4'd6, acc); check("t3_acc_c", 64'(acc), 64'd1);
    check("t3_full", 64'(in_ready), 64'd0);
    push_one(32'h4040_0000, 4'd7, acc); check("t3_reject_d", 64'(acc), 64'd0);
    wait_valid(-1, "t3a"); check("t3_full_held", 64'(in_ready), 64'd0); consume("t3a");
    wait_valid(-1, "t3b"); consume("t3b");
    wait_valid(-1, "t3c"); consume("t3c");
    repeat (8) @(negedge clock);
    check("t3_no_extra", 64'(out_valid), 64'd0);
    check("t3_in_ready", 64'(in_ready), 64'd1);

    // Watchdog timeout; a late root_ready must not disturb the held result
    push_one(32'h4123_45A5, 4'd9, acc);
    wait_valid(TMO + 2, "t4");
    check("t4_q_const", out_q, 64'h7FC0_0000);
    check("t4_err_const", 64'(out_err), 64'd1);
    @(posedge clock); #1 rm_inject = 1'b1;
    repeat (2) @(negedge clock);
    check("t4_late_valid", 64'(out_valid), 64'd1);
    check("t4_late_q", out_q, 64'h7FC0_0000);
    check("t4_late_err", 64'(out_err), 64'd1);
    consume("t4");

    // Reset while waiting on the root unit, with a second request buffered
    push_one(32'h3F80_00A5, 4'd10, acc);
    push_one(32'h4040_0000, 4'd11, acc);
    repeat (5) @(negedge clock);
    check("t5_pre_valid", 64'(out_valid), 64'd0);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    exp_q.delete();
    issue_q.delete();
    s0 = n_starts;
    @(posedge clock); #1 rm_inject = 1'b1;
    repeat (8) @(negedge clock);
    check("t5_valid", 64'(out_valid), 64'd0);
    check("t5_in_ready", 64'(in_ready), 64'd1);
    check("t5_out_q", out_q, 64'd0);
    check("t5_no_start", 64'(n_starts), 64'(s0));

    // Denormal flushes to zero in cycle 2
    push_one(32'h0040_0000, 4'd12, acc);
    wait_valid(1, "t6");
    check("t6_q_const", out_q, 64'd0);
    consume("t6");

    // Randomized traffic with random back-pressure
    rm_delay = 0;
    fork
      begin
        logic [31:0] d;
        logic [TAG_W-1:0] t;
        logic ok;
        int tries;
        for (int i = 0; i < 80; i++) begin
          d = rand_operand();
          t = TAG_W'($urandom);
          repeat ($urandom_range(0, 2)) @(negedge clock);
          ok = 1'b0;
          tries = 0;
          while (!ok && tries < 200) begin
            push_one(d, t, ok);
            tries++;
          end
          if (!ok) check("rnd_push_stall", 64'd0, 64'd1);
        end
        prod_done = 1'b1;
      end
      begin
        int budget = 0;
        while (!(prod_done && exp_q.size() == 0) && budget < 40000) begin
          @(negedge clock);
          budget++;
          out_ready = ($urandom_range(0, 3) != 0);
          if (out_valid && out_ready) compare_pop("rnd");
        end
        out_ready = 1'b0;
        check("rnd_drained", 64'(exp_q.size()), 64'd0);
      end
    join

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fp_sqrt_issue_ctrl.md
# fp_sqrt_issue_ctrl

- Front-end controller for the iterative floating-point square-root unit (`root_newton` / `root_goldschmidt` port set: `d`, `start`, `q`, `busy`, `ready`).
- Accepts tagged single-precision operands on a valid/ready handshake and buffers them in a small FIFO.
- Resolves IEEE-754 special cases locally, so they never reach the root unit. For normal operands it sequences the root unit and holds the tagged result until the consumer takes it.
- Sits between the ALU issue stage and the root unit. Guards against a hung iteration with a watchdog.

## Interface
Parameters:
- `DEPTH`, 2 — request FIFO entries (power of two, ≥2)
- `TAG_W`, 4 — request tag width
- `TIMEOUT`, 64 — maximum cycles spent in WAIT before abort

Ports:
- `clock`  in  1  — single clock; all logic on its rising edge
- `reset`  in  1  — synchronous, active-high
- `in_valid`  in  1  — request present
- `in_ready`  out  1  — FIFO can accept
- `in_d`  in  32  — IEEE-754 single operand
- `in_tag`  in  TAG_W  — request tag
- `root_start`  out  1  — one-cycle start pulse to root unit
- `root_d`  out  32  — operand to root unit
- `root_q`  in  32  — root unit result
- `root_busy`  in  1  — root unit busy (observed, not required)
- `root_ready`  in  1  — one-cycle pulse; `root_q` valid in that cycle
- `out_valid`  out  1  — result held
- `out_ready`  in  1  — consumer accepts
- `out_q`  out  32  — result
- `out_tag`  out  TAG_W  — tag of result
- `out_err`  out  1  — result came from a watchdog timeout

## Operation
- FIFO:
  - push on `in_valid & in_ready`.
  - `in_ready = !full`. It is not asserted on a same-cycle pop when full.
- Operand classification at FIFO head (s = bit31, e = [30:23], f = [22:0]). The first matching rule applies:
  - NaN (e=FF, f≠0) → input with bit22 forced 1
  - e=0 (zero or denormal, flushed) → {s, 31'b0}
  - s=1 → 0x7FC00000
  - +inf → 0x7F800000
  - otherwise normal
- IDLE:
  - If the FIFO is non-empty, pop the head into the op/tag registers.
  - Special operand → HOLD, with the result loaded.
  - Normal operand → ISSUE.
- ISSUE:
  - `root_start`=1 and `root_d`=op for exactly one cycle.
  - Clear the watchdog counter.
  - → WAIT.
- WAIT:
  - On `root_ready`, capture `root_q`, `out_err`=0 → HOLD.
  - Else increment the counter. When it reaches TIMEOUT−1 without `root_ready`, load 0x7FC00000, `out_err`=1 → HOLD.
- HOLD:
  - `out_valid`=1; `out_q`, `out_tag` and `out_err` are stable.
  - On `out_ready`, go to IDLE.
- `root_ready` outside WAIT is ignored, including a late pulse after a timeout.
- `root_d` holds the op register at all times. It is only meaningful while `root_start` is high.

## Timing
- Reset values:
  - state IDLE, FIFO empty, `in_ready`=1
  - `root_start`=0, `root_d`=0
  - `out_valid`=0, `out_q`=0, `out_tag`=0, `out_err`=0
  - watchdog counter 0
- Reset mid-operation:
  - FIFO and the held result are discarded.
  - A `root_ready` arriving after reset is ignored.
- Push accepted at edge 0:
  - Special case: `out_valid` high in cycle 2.
  - Normal case: `root_start` high in cycle 2; WAIT from cycle 3. If `root_ready` pulses in cycle k, `out_valid` is high in cycle k+1.
- Back-to-back: after the HOLD handshake at edge n, IDLE in cycle n+1. The next result follows the same latencies from that point.
- Timeout: `out_valid` rises exactly TIMEOUT+1 cycles after ISSUE.
- Push while full is rejected; the data is not stored.
- Simultaneous push and pop on a non-full FIFO are both performed.

## Structure
- Package `fp_sqrt_pkg` holds:
  - state enum {IDLE, ISSUE, WAIT, HOLD}
  - constants QNAN=32'h7FC00000, PINF=32'h7F800000
  - classification function returning {is_special, special_result}
- Sub-module `fp_req_fifo`:
  - synchronous FIFO, parameters DEPTH and width 32+TAG_W
  - signals `push`, `pop`, `full`, `empty`, `head`
  - wrap-around pointers plus an occupancy count

## Test plan
- Push 0x40800000 (4.0), tag 3; model returns 0x40000000 five cycles after start → `root_start` in cycle 2, then `out_q`=0x40000000, `out_tag`=3, `out_err`=0.
- Push 0xC0000000, 0x80000000 and 0x7F800001 → outputs 0x7FC00000, 0x80000000 and 0x7FC00001 in order; `root_start` never asserted.
- With `out_ready`=0, push three normal operands → third push sees `in_ready`=0 once two entries plus the held result are occupied; draining with `out_ready`=1 returns all tags in order.
- Model never asserts `root_ready` → `out_q`=0x7FC00000, `out_err`=1 after TIMEOUT+1 cycles; a late `root_ready` pulse changes nothing.
- Assert `reset` during WAIT, then pulse `root_ready` → `out_valid` stays 0, FIFO empty, `in_ready`=1.
- Push 0x00400000 (denormal) → `out_q`=0x00000000 in cycle 2.
